// File: rtl/lvds_pkg.sv
// Shared defaults and helpers for the LVDS serializer/deserializer loopback.
// Contents:
//   SER_FACTOR_DEF  - default bits per word (clk cycles per frame)
//   LOCK_CYCLES_DEF - default clk cycles from reset release to tx_locked
//   clog2()         - counter width for a given modulus
package lvds_pkg;

   localparam int SER_FACTOR_DEF  = 8;
   localparam int LOCK_CYCLES_DEF = 16;

   // Width needed to count 0..value-1; elaborated as a constant function.
   function automatic int clog2(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/lvds_rx_deser.sv
// RX side of the LVDS loopback: frames the serial stream on rising edges of
// the incoming frame clock, applies bit-slip, and assembles recovered words.
// Ports:
//   clk, rst   - bit-rate clock, asynchronous active-high reset
//   ser        - serial data (MSB of each word first)
//   frm        - frame clock, sampled as data; its rising edge marks bit MSB
//   align      - bit-slip request, one slip per rising edge
//   locked     - set by the first frame-clock rising edge, held until reset
//   data       - recovered word, updated once per word
//   outclock   - recovered word clock (high for the first half of a word)
module lvds_rx_deser
   import lvds_pkg::*;
#(
   parameter int SER_FACTOR = SER_FACTOR_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ser,
   input  logic                  frm,
   input  logic                  align,
   output logic                  locked,
   output logic [SER_FACTOR-1:0] data,
   output logic                  outclock
);

   localparam int             CW       = clog2(SER_FACTOR);
   localparam logic [CW-1:0]  LAST_BIT = CW'(SER_FACTOR - 1);
   localparam logic [CW-1:0]  HALF     = CW'(SER_FACTOR / 2);

   logic                  frm_prev;
   logic                  align_prev;
   logic [CW-1:0]         slip;
   logic [CW-1:0]         rx_cnt;    // position of the next sample within a word
   logic [SER_FACTOR-1:0] shift;

   logic                  frame_rise;
   logic                  slip_req;
   logic [CW-1:0]         slip_now;
   logic [CW-1:0]         pos;

   // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      frame_rise = frm & ~frm_prev;
      slip_req   = align & ~align_prev;
      // A slip landing on a re-sync edge takes effect on that very edge.
      slip_now   = slip + CW'(slip_req);
      // The frame edge samples the word MSB; each slip pushes the word
      // boundary one bit later, so that sample sits 'slip' positions from
      // the end of the slipped word.
      pos        = frame_rise ? (CW'(0) - slip_now) : rx_cnt;
   end

   // NOTE: sequential state uses <= so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frm_prev   <= 1'b0;
         align_prev <= 1'b0;
         slip       <= '0;
         rx_cnt     <= '0;
         shift      <= '0;
         locked     <= 1'b0;
         data       <= '0;
      end else begin
         frm_prev   <= frm;
         align_prev <= align;
         slip       <= slip_now;
         shift      <= {shift[SER_FACTOR-2:0], ser};
         if (frame_rise) locked <= 1'b1;
         if (locked || frame_rise) begin
            rx_cnt <= pos + 1'b1;
            if (pos == LAST_BIT) data <= {shift[SER_FACTOR-2:0], ser};
         end
      end
   end

   assign outclock = locked & (rx_cnt < HALF);

endmodule

// File: rtl/lvds_serdes_loopback.sv
// Behavioural single-clock LVDS serializer/deserializer pair for loopback
// testing. TX latches one word per frame and shifts it out MSB first with a
// forwarded frame clock; RX (lvds_rx_deser) re-frames and recovers words.
// Build option: define LVDS_INTERNAL_LOOPBACK_EN to feed the RX path from the
// internal tx_out / tx_outclock instead of the rx_in / rx_inclock ports.
// Ports:
//   clk, rst       - bit-rate clock, asynchronous active-high reset
//   tx_in          - parallel word, sampled only on the frame's first edge
//   tx_out         - serial data, MSB first
//   tx_outclock    - forwarded frame clock, high for the first half word
//   tx_coreclock   - parallel-side word clock, same waveform as tx_outclock
//   tx_locked      - TX "PLL" locked, LOCK_CYCLES clks after reset release
//   tx_done        - one-cycle pulse while bit 0 is on the line
//   rx_data_align  - bit-slip request (rising-edge sensitive)
//   rx_in          - serial data in
//   rx_inclock     - frame clock in
//   rx_locked      - RX framed
//   rx_data        - recovered word
//   rx_outclock    - recovered word clock
module lvds_serdes_loopback
   import lvds_pkg::*;
#(
   parameter int SER_FACTOR  = SER_FACTOR_DEF,
   parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SER_FACTOR-1:0] tx_in,
   output logic                  tx_out,
   output logic                  tx_outclock,
   output logic                  tx_coreclock,
   output logic                  tx_locked,
   output logic                  tx_done,
   input  logic                  rx_data_align,
   input  logic                  rx_in,
   input  logic                  rx_inclock,
   output logic                  rx_locked,
   output logic [SER_FACTOR-1:0] rx_data,
   output logic                  rx_outclock
);

   localparam int             CW        = clog2(SER_FACTOR);
   localparam int             LW        = clog2(LOCK_CYCLES + 1);
   localparam logic [CW-1:0]  LAST_BIT  = CW'(SER_FACTOR - 1);
   localparam logic [CW-1:0]  HALF      = CW'(SER_FACTOR / 2);
   localparam logic [LW-1:0]  LOCK_LAST = LW'(LOCK_CYCLES - 1);

   logic [LW-1:0]         lock_cnt;
   logic [CW-1:0]         cnt;
   logic [SER_FACTOR-1:0] shreg;
   logic                  rx_ser;
   logic                  rx_frm;

   // Lock counter stops once locked; tx_locked holds until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_cnt  <= '0;
         tx_locked <= 1'b0;
      end else if (!tx_locked) begin
         lock_cnt <= lock_cnt + 1'b1;
         if (lock_cnt == LOCK_LAST) tx_locked <= 1'b1;
      end
   end

   // The frame's first edge drives tx_in's MSB straight onto the line so it
   // appears in the cycle right after the load; later edges present the next
   // bit of the shifting word. cnt wraps naturally (SER_FACTOR is 2**CW).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         shreg       <= '0;
         tx_out      <= 1'b0;
         tx_outclock <= 1'b0;
         tx_done     <= 1'b0;
      end else if (!tx_locked) begin
         cnt         <= '0;
         tx_out      <= 1'b0;
         tx_outclock <= 1'b0;
         tx_done     <= 1'b0;
      end else begin
         cnt         <= cnt + 1'b1;
         tx_outclock <= (cnt < HALF);
         tx_done     <= (cnt == LAST_BIT);
         if (cnt == '0) begin
            shreg  <= tx_in;
            tx_out <= tx_in[SER_FACTOR-1];
         end else begin
            shreg  <= shreg << 1;
            tx_out <= shreg[SER_FACTOR-2];
         end
      end
   end

   assign tx_coreclock = tx_outclock;

`ifdef LVDS_INTERNAL_LOOPBACK_EN
   logic loopback_unused;
   assign loopback_unused = rx_in | rx_inclock;
   assign rx_ser          = tx_out;
   assign rx_frm          = tx_outclock;
`else
   assign rx_ser = rx_in;
   assign rx_frm = rx_inclock;
`endif

   lvds_rx_deser #(
      .SER_FACTOR (SER_FACTOR)
   ) u_rx (
      .clk      (clk),
      .rst      (rst),
      .ser      (rx_ser),
      .frm      (rx_frm),
      .align    (rx_data_align),
      .locked   (rx_locked),
      .data     (rx_data),
      .outclock (rx_outclock)
   );

endmodule

// File: tb/tb_lvds_serdes_loopback.sv
// Self-checking bench for lvds_serdes_loopback (SER_FACTOR=8, LOCK_CYCLES=16).
// The serial pins are looped back externally; with LVDS_INTERNAL_LOOPBACK_EN
// defined the RX pins are tied low instead and the internal path is relied on.
module tb_lvds_serdes_loopback;

   logic       clk;
   logic       rst;
   logic [7:0] tx_in;
   logic       tx_out, tx_outclock, tx_coreclock, tx_locked, tx_done;
   logic       rx_data_align;
   logic       rx_in, rx_inclock;
   logic       rx_locked;
   logic [7:0] rx_data;
   logic       rx_outclock;

`ifdef LVDS_INTERNAL_LOOPBACK_EN
   assign rx_in      = 1'b0;
   assign rx_inclock = 1'b0;
`else
   assign rx_in      = tx_out;
   assign rx_inclock = tx_outclock;
`endif

   lvds_serdes_loopback dut (
      .clk           (clk),
      .rst           (rst),
      .tx_in         (tx_in),
      .tx_out        (tx_out),
      .tx_outclock   (tx_outclock),
      .tx_coreclock  (tx_coreclock),
      .tx_locked     (tx_locked),
      .tx_done       (tx_done),
      .rx_data_align (rx_data_align),
      .rx_in         (rx_in),
      .rx_inclock    (rx_inclock),
      .rx_locked     (rx_locked),
      .rx_data       (rx_data),
      .rx_outclock   (rx_outclock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] tx_in;
      logic       exp_out;
      logic       exp_oclk;
      logic       exp_done;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t       tbl [9];
   int         n_checks = 0;
   int         n_errors = 0;
   int         ecount   = 0;     // clk edges since reset release
   logic [7:0] cur_tx   = '0;    // word the model expects on the line
   int         s_model  = 0;     // expected slip value
   bit         mon_en   = 0;
   bit         sb_en    = 0;
   bit         alt      = 0;
   logic [7:0] sb_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // One clk edge plus the per-cycle reference model of the TX line and RX framing.
   task automatic tick();
      logic [7:0] sampled;
      logic [7:0] exp_w;
      logic [4:0] exp_tx;
      logic [4:0] act_tx;
      int         k;
      sampled = tx_in;
      @(posedge clk);
      #1;
      if (!mon_en) return;
      ecount++;
      k = 0;
      if (ecount >= 17) begin
         k = (ecount - 17) % 8;
         if (k == 0) begin
            if (sb_en && sb_q.size() > 0) begin
               exp_w = sb_q.pop_front();
               check("rx_word", {24'd0, rx_data}, {24'd0, exp_w});
            end
            if (sb_en) sb_q.push_back(sampled);
            cur_tx = sampled;
         end
         exp_tx = {1'b1, cur_tx[7-k], k < 4, k < 4, k == 7};
      end else begin
         exp_tx = {ecount >= 16, 4'b0000};
      end
      act_tx = {tx_locked, tx_out, tx_outclock, tx_coreclock, tx_done};
      check("tx_state", {27'd0, act_tx}, {27'd0, exp_tx});
      check("rx_locked", {31'd0, rx_locked}, {31'd0, ecount >= 18});
      if (sb_en) check("rx_outclock", {31'd0, rx_outclock}, {31'd0, (ecount >= 18) && (k < 4)});
   endtask

   // One aligned frame of word w; optional slip pulse raised before tick slip_j.
   task automatic frame(input logic [7:0] w, input bit do_slip, input int slip_j, input bit chk);
      logic [15:0] pair;
      int          ck_s;
      pair = {cur_tx, w};
      ck_s = (do_slip && slip_j == 1) ? (s_model + 1) % 8 : s_model;
      tx_in = w;
      for (int j = 0; j < 8; j++) begin
         if (do_slip && j == slip_j) rx_data_align = 1'b1;
         if (j == 6) rx_data_align = 1'b0;
         tick();
         if (chk && j == ck_s) check("rx_slip", {24'd0, rx_data}, {24'd0, 8'(pair >> (8 - ck_s))});
      end
      if (do_slip) s_model = (s_model + 1) % 8;
   endtask

   task automatic alt_frame(input bit do_slip, input int slip_j, input bit chk);
      frame(alt ? 8'h22 : 8'hF1, do_slip, slip_j, chk);
      alt = ~alt;
   endtask

   task automatic check_cleared(input string name);
      check(name, {19'd0, tx_out, tx_outclock, tx_coreclock, tx_locked, tx_done,
                   rx_locked, rx_outclock, rx_data}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int done_cnt;

      // Loopback frame of 0xF1 = 1,1,1,1,0,0,0,1 starting at the first load edge.
      tbl[0] = '{8'hF1, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[1] = '{8'hF1, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[2] = '{8'hF1, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[3] = '{8'hF1, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[4] = '{8'hF1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[5] = '{8'hF1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[6] = '{8'hF1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[7] = '{8'hF1, 1'b1, 1'b0, 1'b1, 8'h00};
      tbl[8] = '{8'hF1, 1'b1, 1'b1, 1'b0, 8'hF1};

      // 1. Reset and lock timing
      rst           = 1'b0;
      tx_in         = 8'hF1;
      rx_data_align = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_cleared("reset_state");
      rst    = 1'b0;
      mon_en = 1;
      sb_en  = 1;
      repeat (15) tick();
      check("lock_before", {31'd0, tx_locked}, 32'd0);
      tick();
      check("lock_at_16", {31'd0, tx_locked}, 32'd1);

      // 2. 0xF1 held: bit sequence, word clocks, done pulse, first recovered word
      for (int i = 0; i < 9; i++) begin
         tx_in = tbl[i].tx_in;
         tick();
         check("vec_tx_out",  {31'd0, tx_out},      {31'd0, tbl[i].exp_out});
         check("vec_outclk",  {31'd0, tx_outclock}, {31'd0, tbl[i].exp_oclk});
         check("vec_coreclk", {31'd0, tx_coreclock},{31'd0, tbl[i].exp_oclk});
         check("vec_done",    {31'd0, tx_done},     {31'd0, tbl[i].exp_done});
         check("vec_rx_data", {24'd0, rx_data},     {24'd0, tbl[i].exp_rx});
      end
      done_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (tx_done) done_cnt++;
      end
      check("done_count", done_cnt, 2);
      check("rx_locked_on", {31'd0, rx_locked}, 32'd1);

      // 3. tx_in changing between load edges: only the load-edge value counts
      for (int i = 0; i < 32; i++) begin
         tx_in = ((i / 2) % 2) ? 8'h22 : 8'hF1;
         tick();
      end
      for (int i = 0; i < 48; i++) begin
         tx_in = ((i / 3) % 2) ? 8'h22 : 8'hF1;
         tick();
      end
      for (int i = 0; i < 48; i++) begin
         tx_in = 8'($urandom);
         tick();
      end

      // 4. Bit-slip over alternating 0xF1/0x22; first slip coincides with a re-sync edge
      sb_en = 0;
      sb_q.delete();
      alt = 0;
      alt_frame(0, 0, 1);
      alt_frame(0, 0, 1);
      for (int n = 0; n < 8; n++) begin
         alt_frame(1, (n == 0) ? 1 : 2, n == 0);
         alt_frame(0, 0, 0);
         alt_frame(0, 0, 1);
         alt_frame(0, 0, 1);
      end
      check("slip_wrapped", s_model, 0);
      sb_en = 1;
      alt_frame(0, 0, 0);
      alt_frame(0, 0, 0);
      alt_frame(0, 0, 0);

      // 5. Reset mid-word, then re-acquire lock and framing
      tx_in = 8'h22;
      repeat (3) tick();
      mon_en = 0;
      #2 rst = 1'b1;
      rx_data_align = 1'b0;
      #1 check_cleared("reset_async");
      @(posedge clk);
      #1 check_cleared("reset_held");
      rst     = 1'b0;
      mon_en  = 1;
      ecount  = 0;
      cur_tx  = '0;
      s_model = 0;
      sb_q.delete();
      repeat (16) tick();
      for (int i = 0; i < 40; i++) begin
         case (i / 8)
            0:       tx_in = 8'h5A;
            1:       tx_in = 8'hA5;
            2:       tx_in = 8'h3C;
            default: tx_in = 8'hC3;
         endcase
         tick();
         if (i == 7) check("post_reset_pre", {24'd0, rx_data}, 32'd0);
         if (i == 8) check("post_reset_first", {24'd0, rx_data}, 32'h5A);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
